spart: RTL and testbench

SPART -- requirements
Module: spart

---
 rtl/spart_pkg.sv | 32 +++
 rtl/spart_baud_gen.sv | 57 +++++
 rtl/spart.sv | 243 ++++++++++++++++++++++++
 tb/tb_spart.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port.
// Holds the bus register map, the TX/RX state encodings, the oversampling
// ratio and the power-on baud divisor.
package spart_pkg;

    // Register map as seen on ioaddr
    localparam logic [1:0] ADDR_BUF    = 2'b00;  // TX holding / RX buffer
    localparam logic [1:0] ADDR_STATUS = 2'b01;  // {6'b0, rda, tbr}
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;  // divisor[7:0]
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;  // divisor[15:8]

    // Baud ticks per serial bit
    localparam int OVERSAMPLE = 16;

    // 4800 baud at 100 MHz with 16x oversampling
    localparam logic [15:0] DIV_RESET = 16'h0516;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator for SPART.
// Holds the 16-bit divisor register and a down-counter that pulses tick_o
// for one clock every divisor clocks (every clock for divisor 0 or 1).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   div_lo_we_i     load divisor[7:0] from wdata_i and restart the counter
//   div_hi_we_i     load divisor[15:8] from wdata_i and restart the counter
//   wdata_i [7:0]   write data from the bus
//   divisor_o[15:0] current divisor, for bus read-back
//   tick_o          one-clock oversampling tick
module spart_baud_gen #(
    parameter logic [15:0] DIV_RESET = spart_pkg::DIV_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_lo_we_i,
    input  logic        div_hi_we_i,
    input  logic [7:0]  wdata_i,
    output logic [15:0] divisor_o,
    output logic        tick_o
);

    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;

    // Counter values 0 and 1 both count as terminal so a divisor of 0
    // degenerates to a tick every clock instead of wrapping to 65535.
    assign tick_o    = (cnt_q <= 16'd1);
    assign divisor_o = div_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        div_d = div_q;
        if (div_lo_we_i) div_d[7:0]  = wdata_i;
        if (div_hi_we_i) div_d[15:8] = wdata_i;

        if (div_lo_we_i || div_hi_we_i) begin
            cnt_d = div_d;
        end else if (tick_o) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_RESET;
            cnt_q <= DIV_RESET;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart.sv
// SPART: bus-programmable 8N1 UART with 16x oversampling.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   iocs          chip select
//   iorw          1 = read from SPART, 0 = write to SPART
//   ioaddr[1:0]   register select (buffer, status, divisor low/high)
//   databus[7:0]  bidirectional bus, driven only during a selected read
//   rda           receive data available
//   tbr           transmit buffer ready
//   txd           serial output, idle high
//   rxd           serial input, asynchronous, idle high
module spart #(
    parameter logic [15:0] DIV_RESET = spart_pkg::DIV_RESET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    import spart_pkg::*;

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

    // ---------------------------------------------------------------- bus
    logic        wr_en, rd_en, rd_buf, tx_load;
    logic [7:0]  rd_data;
    logic [15:0] divisor;
    logic        tick;

    assign wr_en   = iocs & ~iorw;
    assign rd_en   = iocs & iorw;
    assign rd_buf  = rd_en && (ioaddr == ADDR_BUF);

    spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
        .clk         (clk),
        .rst         (rst),
        .div_lo_we_i (wr_en && (ioaddr == ADDR_DIV_LO)),
        .div_hi_we_i (wr_en && (ioaddr == ADDR_DIV_HI)),
        .wdata_i     (databus),
        .divisor_o   (divisor),
        .tick_o      (tick)
    );

    // ---------------------------------------------------------------- TX
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q,   tx_bit_d;
    logic [3:0] tx_tick_q,  tx_tick_d;
    logic       txd_q,      txd_d;
    logic       tbr_q,      tbr_d;

    // ---------------------------------------------------------------- RX
    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_bit_q,   rx_bit_d;
    logic [3:0] rx_tick_q,  rx_tick_d;
    logic [7:0] rx_buf_q,   rx_buf_d;
    logic       rda_q,      rda_d;
    logic       rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic       rx_done;

    assign tx_load = wr_en && (ioaddr == ADDR_BUF) && tbr_q;

    assign txd = txd_q;
    assign tbr = tbr_q;
    assign rda = rda_q;

    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            ADDR_BUF:    rd_data = rx_buf_q;
            ADDR_STATUS: rd_data = {6'b0, rda_q, tbr_q};
            ADDR_DIV_LO: rd_data = divisor[7:0];
            ADDR_DIV_HI: rd_data = divisor[15:8];
            default:     rd_data = 8'h00;
        endcase
    end

    assign databus = rd_en ? rd_data : 8'bz;

    // TX next state. txd is computed here and registered so the line never
    // glitches; it changes on the same edge as the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_tick_d  = tx_tick_q;
        txd_d      = txd_q;
        tbr_d      = tbr_q;

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_load) begin
                    tx_shift_d = databus;
                    tx_state_d = TX_START;
                    tx_tick_d  = 4'd0;
                    txd_d      = 1'b0;
                    tbr_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == LAST_TICK) begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = 3'd0;
                        txd_d      = tx_shift_q[0];
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == LAST_TICK) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = TX_STOP;
                            txd_d      = 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_shift_d = tx_shift_q >> 1;
                            txd_d      = tx_shift_q[1];
                        end
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == LAST_TICK) begin
                        tx_state_d = TX_IDLE;
                        tbr_d      = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX next state. Start detection waits half a bit and re-checks the
    // line so short low glitches are rejected; every later sample lands
    // one full bit after the previous, i.e. near mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_tick_d  = rx_tick_q;
        rx_buf_d   = rx_buf_q;
        rx_done    = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RX_START;
                    rx_tick_d  = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == MID_TICK) begin
                        rx_tick_d  = 4'd0;
                        rx_bit_d   = 3'd0;
                        rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == LAST_TICK) begin
                        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == LAST_TICK) begin
                        rx_state_d = RX_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx_sync2_q) begin
                            rx_buf_d = rx_shift_q;
                            rx_done  = 1'b1;
                        end
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // A completing frame takes priority over a simultaneous buffer read.
        rda_d = rda_q;
        if (rd_buf)  rda_d = 1'b0;
        if (rx_done) rda_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 8'h00;
            tx_bit_q   <= 3'd0;
            tx_tick_q  <= 4'd0;
            txd_q      <= 1'b1;
            tbr_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= 8'h00;
            rx_bit_q   <= 3'd0;
            rx_tick_q  <= 4'd0;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_tick_q  <= tx_tick_d;
            txd_q      <= txd_d;
            tbr_q      <= tbr_d;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_tick_q  <= rx_tick_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
            // Two-flop synchronizer, plus one more stage for edge detection
            rx_sync1_q <= rxd;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: register table, baud tick rate, TX frame
// scoreboard, RX frame scoreboard, glitch/framing/overrun, full duplex and
// reset in the middle of a transmission.
module tb_spart;
    import spart_pkg::*;

    logic       clk;
    logic       rst;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;

    logic [7:0] tb_wdata;
    logic       tb_drive;

    assign databus = tb_drive ? tb_wdata : 8'bz;

    spart dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboards
    logic       tx_q[$];   // expected txd levels, one per bit
    logic [7:0] rx_q[$];   // expected rx_buf contents
    logic       model_rda = 1'b0;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_wdata = d; tb_drive = 1'b1;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dut.tick) cnt++;
        end
    endtask

    // Load a byte for transmission and queue its expected frame.
    task automatic tx_send(input logic [7:0] b);
        bus_write(ADDR_BUF, b);
        check("tbr_low_after_load", tbr, 1'b0);
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
        tx_q.push_back(1'b1);
    endtask

    // Samples txd at the middle of each 32-clock bit (divisor 2), starting
    // from the falling edge right after the load edge.
    task automatic tx_monitor();
        logic exp_bit;
        for (int i = 0; i < 10; i++) begin
            repeat (i == 0 ? 16 : 32) @(negedge clk);
            if (tx_q.size() == 0) begin
                check("tx_queue_empty", 1'b1, 1'b0);
            end else begin
                exp_bit = tx_q.pop_front();
                check($sformatf("txd_bit%0d", i), txd, exp_bit);
            end
        end
        check("tbr_low_mid_stop", tbr, 1'b0);
        for (int n = 0; n < 40 && !tbr; n++) @(negedge clk);
        check("tbr_high_after_stop", tbr, 1'b1);
    endtask

    // Drive one frame on rxd at 32 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (model_rda) void'(rx_q.pop_back());
            rx_q.push_back(b);
            model_rda = 1'b1;
        end
        rxd = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (32) @(negedge clk);
        end
        rxd = stop;
        repeat (32) @(negedge clk);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Wait for rda, read the buffer and compare against the scoreboard.
    task automatic rx_check(input string name);
        logic [7:0] d;
        logic [7:0] exp;
        for (int n = 0; n < 200 && !rda; n++) @(negedge clk);
        check({name, "_rda_set"}, rda, 1'b1);
        bus_read(ADDR_BUF, d);
        if (rx_q.size() == 0) begin
            check({name, "_rx_queue_empty"}, 1'b1, 1'b0);
        end else begin
            exp = rx_q.pop_front();
            check({name, "_data"}, d, exp);
        end
        model_rda = 1'b0;
        check({name, "_rda_cleared"}, rda, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        int         cnt;

        rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
        rxd = 1'b1; tb_drive = 1'b0; tb_wdata = 8'h00;

        vecs[0]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h01};
        vecs[1]  = '{1'b0, ADDR_BUF,    8'h00, 8'h00};
        vecs[2]  = '{1'b0, ADDR_DIV_LO, 8'h00, 8'h16};
        vecs[3]  = '{1'b0, ADDR_DIV_HI, 8'h00, 8'h05};
        vecs[4]  = '{1'b1, ADDR_STATUS, 8'hFF, 8'h00};
        vecs[5]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h01};
        vecs[6]  = '{1'b1, ADDR_DIV_LO, 8'h02, 8'h00};
        vecs[7]  = '{1'b1, ADDR_DIV_HI, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, ADDR_DIV_LO, 8'h00, 8'h02};
        vecs[9]  = '{1'b0, ADDR_DIV_HI, 8'h00, 8'h00};
        vecs[10] = '{1'b0, ADDR_STATUS, 8'h00, 8'h01};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_txd", txd, 1'b1);
        check("reset_tbr", tbr, 1'b1);
        check("reset_rda", rda, 1'b0);

        // Register map through a table of bus operations
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
            end
        end

        // Baud rate: divisor 2 -> every other clock; divisor 0 -> every clock
        repeat (4) @(negedge clk);
        count_ticks(20, cnt);
        check("ticks_div2", cnt, 10);
        bus_write(ADDR_DIV_LO, 8'h00);
        repeat (2) @(negedge clk);
        count_ticks(10, cnt);
        check("ticks_div0", cnt, 10);
        bus_write(ADDR_DIV_LO, 8'h02);

        // TX of 0xA5 with a write attempted mid-frame that must be ignored
        repeat (4) @(negedge clk);
        tx_send(8'hA5);
        fork
            tx_monitor();
            begin
                repeat (100) @(negedge clk);
                bus_write(ADDR_BUF, 8'hFF);
            end
        join

        // RX of 0x3C
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        rx_check("rx_3c");

        // Short low glitch must not start a frame
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_no_rda", rda, 1'b0);

        // Framing error: stop bit low, byte dropped
        send_frame(8'h55, 1'b0);
        repeat (64) @(negedge clk);
        check("framing_no_rda", rda, 1'b0);

        // Overrun: second byte overwrites the first, status read keeps rda
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun_rda", rda, 1'b1);
        bus_read(ADDR_STATUS, d);
        check("overrun_status", d, 8'h03);
        check("status_read_keeps_rda", rda, 1'b1);
        rx_check("overrun");

        // Full duplex: transmit 0x5A while receiving 0xC3
        tx_send(8'h5A);
        fork
            tx_monitor();
            send_frame(8'hC3, 1'b1);
        join
        rx_check("duplex");

        // Reset in the middle of the data bits
        repeat (4) @(negedge clk);
        tx_send(8'h81);
        void'(tx_q.pop_front());  // frame is abandoned, drop its expectations
        tx_q.delete();
        repeat (96) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx_txd", txd, 1'b1);
        check("rst_mid_tx_tbr", tbr, 1'b1);
        bus_read(ADDR_DIV_LO, d);
        check("rst_div_lo", d, 8'h16);
        bus_read(ADDR_DIV_HI, d);
        check("rst_div_hi", d, 8'h05);
        repeat (40) @(negedge clk);
        check("rst_txd_stays_idle", txd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
